demux16_reg: RTL

Registered 1-to-16 demultiplexer that scatters a single data bit onto one of sixteen held output bits, the inverse of the 16:1 selection path. It supports direct addressed writes (select on s3..s0) and an auto-incrementing sequential fill that collects 16 serial bits into q. It sits on the write side of the 16-entry bit fields and flag banks that the 16:1 mux reads back, and it produces a one-hot strobe for downstream enables.

---
 rtl/demux16_reg.sv | 107 ++++++++++
 1 files changed

// File: rtl/demux16_reg.sv
// Registered 1-to-16 demultiplexer with direct addressed writes and a 16-bit sequential fill.
// Latency: 1 cycle; q, strobe, ptr, busy and done all update on the edge that samples wr/valid/start.
// Backpressure: none; a fill stalls indefinitely while valid is low, and wr is ignored while filling.
module demux16_reg #(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        d,
  input  logic        s0,
  input  logic        s1,
  input  logic        s2,
  input  logic        s3,
  input  logic        wr,
  input  logic        start,
  input  logic        valid,
  output logic [15:0] q,
  output logic [15:0] strobe,
  output logic [3:0]  ptr,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_q;
  logic [15:0] r_strobe;
  logic [3:0]  r_ptr;
  logic        r_done;

  logic [0:0]  w_state_nxt;
  logic [15:0] w_q_nxt;
  logic [15:0] w_strobe_nxt;
  logic [3:0]  w_ptr_nxt;
  logic        w_done_nxt;
  logic [3:0]  w_sel;
  logic [15:0] w_q_start;

  assign w_sel = {s3, s2, s1, s0};

  // A start either wipes the collected bits or leaves them to be overwritten one by one.
  assign w_q_start = CLEAR_ON_START ? 16'h0000 : r_q;

  // Next-state decode: start outranks wr/valid in both states; strobe/done default to idle.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_strobe_nxt = 16'h0000;
    w_ptr_nxt    = r_ptr;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FILL;
          w_ptr_nxt   = 4'd0;
          w_q_nxt     = w_q_start;
        end else if (wr) begin
          w_q_nxt[w_sel] = d;
          w_strobe_nxt   = 16'h0001 << w_sel;
        end
      end
      ST_FILL: begin
        if (start) begin
          w_ptr_nxt = 4'd0;
          w_q_nxt   = w_q_start;
        end else if (valid) begin
          w_q_nxt[r_ptr] = d;
          w_strobe_nxt   = 16'h0001 << r_ptr;
          w_ptr_nxt      = r_ptr + 4'd1;
          if (r_ptr == 4'd15) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any fill in progress and discards collected bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_q      <= 16'h0000;
      r_strobe <= 16'h0000;
      r_ptr    <= 4'd0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_strobe <= w_strobe_nxt;
      r_ptr    <= w_ptr_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign q      = r_q;
  assign strobe = r_strobe;
  assign ptr    = r_ptr;
  assign busy   = (r_state == ST_FILL);
  assign done   = r_done;

endmodule
